// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with wrap/saturate, load, clear, terminal-count pulse and sticky overflow
//
// Parameters
//   WIDTH        counter width in bits
//   MODULUS      count range 0..MODULUS-1, legal 2..2**WIDTH
//   RESET_VALUE  value taken on reset and on clear, must be < MODULUS
//   PRESCALE     (only with UPDOWN_COUNTER_PRESCALE_EN) enabled cycles per count step
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous active-low reset
//   en_i          count enable
//   up_i          1 = increment, 0 = decrement
//   sat_mode_i    0 = wrap at bounds, 1 = saturate at bounds
//   clear_i       synchronous clear to RESET_VALUE
//   load_i        synchronous load of load_value_i (clamped to MODULUS-1)
//   load_value_i  value for load
//   clr_ovf_i     clears the sticky overflow flag
//   value_o       current count
//   tc_o          one-cycle terminal-count pulse per bound event
//   ovf_o         sticky overflow/underflow flag
//   tick_o        (only with UPDOWN_COUNTER_PRESCALE_EN) high on prescaled step cycles
//
// Optional feature macro: UPDOWN_COUNTER_PRESCALE_EN
module updown_counter #(
  parameter int WIDTH       = 8,
  parameter int MODULUS     = 256,
  parameter int RESET_VALUE = 0
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE    = 4
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             sat_mode_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] value_o,
  output logic             tc_o,
  output logic             ovf_o
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  ,
  output logic             tick_o
`endif
);
  // Upper bound kept WIDTH+1 bits wide so MODULUS == 2**WIDTH compares cleanly
  localparam logic [WIDTH:0]   MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);
  logic [WIDTH-1:0] value_q, value_d, load_clamped;
  logic             tc_q, tc_d, ovf_q, ovf_d;
  logic             step, bound, at_top, at_bot, idle;
  // clear or load overrides any count step on this edge
  assign idle = clear_i | load_i;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  localparam int             PW    = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PLAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q;
  assign step = en_i & (pre_q == PLAST);
  always_comb pre_d = idle ? '0 : !en_i ? pre_q : step ? '0 : pre_q + 1'b1;
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= step & ~idle;
    end
  end
  assign tick_o = tick_q;
`else
  assign step = en_i;
`endif
  assign at_top       = {1'b0, value_q} == MAX;
  assign at_bot       = value_q == '0;
  assign bound        = step & ~idle & (up_i ? at_top : at_bot);
  assign load_clamped = ({1'b0, load_value_i} > MAX) ? TOP : load_value_i;
  always_comb begin
    value_d = clear_i ? RST :
              load_i  ? load_clamped :
              !step   ? value_q :
              bound   ? (sat_mode_i ? value_q : up_i ? '0 : TOP) :
              up_i    ? value_q + 1'b1 : value_q - 1'b1;
    tc_d    = bound;
    // a bound event on the same edge as clr_ovf keeps the flag set
    ovf_d   = bound | (ovf_q & ~clr_ovf_i);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      value_q <= RST;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign value_o = value_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;
endmodule
